// File: rtl/ram_block_copier_pkg.sv
// Shared constants and state type for the RAM block copier.
package ram_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 10;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LD_SRC = 3'd1,
      READ   = 3'd2,
      LD_DST = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5
   } copier_state_t;

endpackage

// File: rtl/ram_block_copier_if.sv
// RAM-side bus between the copier (master) and the single-port RAM (slave).
interface ram_block_copier_if #(
   parameter int ADDR_W = ram_pkg::ADDR_W,
   parameter int DATA_W = ram_pkg::DATA_W
);

   logic              EN_AddressRegRead;
   logic [ADDR_W-1:0] address;
   logic              EN_read_from_RAM;
   logic              EN_write_to_RAM;
   logic [DATA_W-1:0] data_from_ram;
   logic [DATA_W-1:0] data_to_ram;

   modport master (
      output EN_AddressRegRead,
      output address,
      output EN_read_from_RAM,
      output EN_write_to_RAM,
      output data_to_ram,
      input  data_from_ram
   );

   modport slave (
      input  EN_AddressRegRead,
      input  address,
      input  EN_read_from_RAM,
      input  EN_write_to_RAM,
      input  data_to_ram,
      output data_from_ram
   );

endinterface

// File: rtl/ram_block_copier.sv
// Copies a block of words inside one RAM, one word per four cycles, ascending index order.
//
// state  | meaning
// IDLE   | waiting for start; all RAM controls low
// LD_SRC | load RAM address register with src_base+idx
// READ   | RAM drives data; captured into hold at closing edge
// LD_DST | load RAM address register with dst_base+idx
// WRITE  | RAM writes hold; idx advances
// DONE   | one-cycle done pulse
module ram_block_copier #(
   parameter int ADDR_W = ram_pkg::ADDR_W,
   parameter int DATA_W = ram_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] length,
   output logic              busy,
   output logic              done,
   ram_block_copier_if.master ram
);

   import ram_pkg::*;

   copier_state_t     state;
   logic [ADDR_W-1:0] src_base;
   logic [ADDR_W-1:0] dst_base;
   logic [ADDR_W-1:0] len_reg;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] hold;
   logic [ADDR_W-1:0] idx_inc;

   assign idx_inc = idx + ADDR_W'(1);

   // Outputs are registered together with the state they belong to, so the RAM
   // sees settled controls well before its negedge sampling.
   always_ff @(posedge clk) begin
      if (reset) begin
         state                 <= IDLE;
         src_base              <= '0;
         dst_base              <= '0;
         len_reg               <= '0;
         idx                   <= '0;
         hold                  <= '0;
         busy                  <= 1'b0;
         done                  <= 1'b0;
         ram.EN_AddressRegRead <= 1'b0;
         ram.EN_read_from_RAM  <= 1'b0;
         ram.EN_write_to_RAM   <= 1'b0;
         ram.address           <= '0;
         ram.data_to_ram       <= '0;
      end else begin
         ram.EN_AddressRegRead <= 1'b0;
         ram.EN_read_from_RAM  <= 1'b0;
         ram.EN_write_to_RAM   <= 1'b0;
         ram.address           <= '0;
         ram.data_to_ram       <= '0;
         done                  <= 1'b0;

         unique case (state)
            IDLE: begin
               if (start) begin
                  src_base <= src_addr;
                  dst_base <= dst_addr;
                  len_reg  <= length;
                  idx      <= '0;
                  if (length != '0) begin
                     state                 <= LD_SRC;
                     busy                  <= 1'b1;
                     ram.EN_AddressRegRead <= 1'b1;
                     ram.address           <= src_addr;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            LD_SRC: begin
               state                <= READ;
               ram.EN_read_from_RAM <= 1'b1;
            end
            READ: begin
               hold                  <= ram.data_from_ram;
               state                 <= LD_DST;
               ram.EN_AddressRegRead <= 1'b1;
               ram.address           <= dst_base + idx;
            end
            LD_DST: begin
               state               <= WRITE;
               ram.EN_write_to_RAM <= 1'b1;
               ram.data_to_ram     <= hold;
            end
            WRITE: begin
               idx <= idx_inc;
               if (idx_inc == len_reg) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state                 <= LD_SRC;
                  ram.EN_AddressRegRead <= 1'b1;
                  ram.address           <= src_base + idx_inc;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_block_copier.sv
// Bench for ram_block_copier: behavioural RAM, per-cycle expected-bus queue, memory shadow.
module tb_ram_block_copier;

   import ram_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [9:0] src_addr, dst_addr, length;
   logic       busy, done;

   ram_block_copier_if #(.ADDR_W(10), .DATA_W(10)) ram ();

   ram_block_copier #(.ADDR_W(10), .DATA_W(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .length   (length),
      .busy     (busy),
      .done     (done),
      .ram      (ram)
   );

   always #5 clk = ~clk;

   // RAM: address register and write both sampled on negedge.
   logic [9:0] mem     [1024];
   logic [9:0] exp_mem [1024];
   logic [9:0] areg = '0;

   always @(negedge clk) begin
      if (ram.EN_AddressRegRead === 1'b1) areg = ram.address;
      if (ram.EN_write_to_RAM === 1'b1) mem[areg] = ram.data_to_ram;
   end
   assign ram.data_from_ram = (ram.EN_read_from_RAM === 1'b1) ? mem[areg] : '0;

   typedef struct packed {
      logic       ld;
      logic       rd;
      logic       wr;
      logic       bsy;
      logic       dn;
      logic [9:0] addr;
      logic [9:0] wd;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   bit   chk_on = 1'b0;
   int   cyc, busy_cnt, done_cnt, done_cyc;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Per-cycle compare of every bus output against the expected queue (idle when empty).
   always @(negedge clk) begin
      exp_t e;
      if (chk_on) begin
         e = '0;
         if (q.size() > 0) e = q.pop_front();
         check("onehot", 32'($countones({ram.EN_AddressRegRead, ram.EN_read_from_RAM,
                                          ram.EN_write_to_RAM}) <= 1), 32'd1);
         check("en_ld", ram.EN_AddressRegRead, e.ld);
         check("en_rd", ram.EN_read_from_RAM, e.rd);
         check("en_wr", ram.EN_write_to_RAM, e.wr);
         check("busy", busy, e.bsy);
         check("done", done, e.dn);
         if (e.ld || !e.bsy) check("address", ram.address, e.addr);
         if (e.wr || !e.bsy) check("wdata", ram.data_to_ram, e.wd);
         cyc++;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // Address must hold steady from just after the edge through the RAM's negedge.
   always begin
      logic       s_ld;
      logic [9:0] s_addr;
      @(posedge clk);
      #1;
      s_ld   = ram.EN_AddressRegRead;
      s_addr = ram.address;
      @(negedge clk);
      if (chk_on && s_ld === 1'b1) check("addr_stable", ram.address, s_addr);
   end

   task automatic run_copy(input logic [9:0] s, input logic [9:0] d, input logic [9:0] n,
                           input int abort_at, input int stray_at);
      int         lim;
      int         budget;
      exp_t       e;
      logic [9:0] sa, da;
      @(posedge clk); #1;
      start = 1'b1; src_addr = s; dst_addr = d; length = n;
      @(posedge clk); #1;
      start = 1'b0; src_addr = 10'h155; dst_addr = 10'h2AA; length = 10'd7;
      cyc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
      lim = (abort_at < 0) ? 4 * int'(n) : abort_at;
      for (int i = 0; i < int'(n); i++) begin
         sa = s + 10'(i);
         da = d + 10'(i);
         e = '0; e.bsy = 1'b1; e.ld = 1'b1; e.addr = sa;
         if (4 * i < lim) q.push_back(e);
         e = '0; e.bsy = 1'b1; e.rd = 1'b1;
         if (4 * i + 1 < lim) q.push_back(e);
         e = '0; e.bsy = 1'b1; e.ld = 1'b1; e.addr = da;
         if (4 * i + 2 < lim) q.push_back(e);
         e = '0; e.bsy = 1'b1; e.wr = 1'b1; e.wd = exp_mem[sa];
         if (4 * i + 3 < lim) begin
            q.push_back(e);
            exp_mem[da] = exp_mem[sa];
         end
      end
      if (abort_at < 0) begin
         e = '0; e.dn = 1'b1;
         q.push_back(e);
      end
      if (stray_at > 0) begin
         repeat (stray_at - 1) @(posedge clk);
         #1; start = 1'b1; src_addr = 10'h100; dst_addr = 10'h101; length = 10'd2;
         @(posedge clk); #1; start = 1'b0;
      end
      if (abort_at > 0) begin
         repeat (abort_at - 1) @(posedge clk);
         #1; reset = 1'b1;
         @(posedge clk); #1; reset = 1'b0;
      end
      budget = 0;
      while (q.size() > 0 && budget < 300) begin
         @(posedge clk);
         budget++;
      end
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
      repeat (3) @(posedge clk);
      #1;
      if (abort_at < 0) begin
         check("done_cycle", done_cyc, 4 * int'(n) + 1);
         check("busy_cycles", busy_cnt, 4 * int'(n));
         check("done_pulses", done_cnt, 1);
      end else begin
         check("abort_no_done", done_cnt, 0);
      end
      for (int k = -1; k <= int'(n); k++) begin
         da = d + 10'(k);
         check("mem", mem[da], exp_mem[da]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = 10'((i * 7) ^ 'h2A);
         exp_mem[i] = mem[i];
      end
      reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
      @(posedge clk); #1;
      chk_on = 1'b1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ens", {ram.EN_AddressRegRead, ram.EN_read_from_RAM, ram.EN_write_to_RAM}, 3'b000);
      repeat (2) @(posedge clk);
      #1; reset = 1'b0;
      repeat (2) @(posedge clk);

      // basic copy
      mem[10'h010] = 10'h3A1; mem[10'h011] = 10'h000; mem[10'h012] = 10'h155; mem[10'h013] = 10'h2AA;
      for (int i = 'h10; i < 'h14; i++) exp_mem[i] = mem[i];
      run_copy(10'h010, 10'h200, 10'd4, -1, 0);
      check("basic_w0", mem[10'h200], 10'h3A1);
      check("basic_w1", mem[10'h201], 10'h000);
      check("basic_w2", mem[10'h202], 10'h155);
      check("basic_w3", mem[10'h203], 10'h2AA);
      check("basic_done_lit", done_cyc, 17);
      check("basic_busy_lit", busy_cnt, 16);

      // wrap-around source
      mem[10'h3FE] = 10'h111; mem[10'h3FF] = 10'h222; mem[10'h000] = 10'h333;
      exp_mem[10'h3FE] = 10'h111; exp_mem[10'h3FF] = 10'h222; exp_mem[10'h000] = 10'h333;
      run_copy(10'h3FE, 10'h001, 10'd3, -1, 0);
      check("wrap_w0", mem[10'h001], 10'h111);
      check("wrap_w2", mem[10'h003], 10'h333);

      // zero length
      run_copy(10'h050, 10'h060, 10'd0, -1, 0);
      check("zero_done_lit", done_cyc, 1);

      // start while busy, then start during DONE
      run_copy(10'h080, 10'h0C0, 10'd4, -1, 5);
      run_copy(10'h090, 10'h0D0, 10'd1, -1, 5);

      // overlapping ranges propagate the first word
      mem[10'h020] = 10'h011; mem[10'h021] = 10'h022; mem[10'h022] = 10'h033;
      for (int i = 'h20; i < 'h23; i++) exp_mem[i] = mem[i];
      run_copy(10'h020, 10'h021, 10'd3, -1, 0);
      check("overlap_w2", mem[10'h023], 10'h011);

      // reset at the edge entering the first WRITE, then a clean copy
      run_copy(10'h040, 10'h300, 10'd4, 3, 0);
      run_copy(10'h040, 10'h300, 10'd2, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
